// File: rtl/result_uart_streamer_pkg.sv
// Shared constants, state encodings and helpers for the result UART streamer.
package result_uart_streamer_pkg;

  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam int         MSG_MAX_BYTES = 13;

  // Message-level sequencing: accept, present first byte, stream, finish.
  typedef enum logic [1:0] {
    MS_IDLE,
    MS_LOAD,
    MS_SEND,
    MS_FIN
  } msg_state_t;

  // Which byte source the message sequencer is currently offering.
  typedef enum logic [1:0] {
    PH_DATA,
    PH_CR,
    PH_LF,
    PH_END
  } phase_t;

  // Per-byte 8N1 framing.
  typedef enum logic [1:0] {
    F_IDLE,
    F_START,
    F_DATA,
    F_STOP
  } frame_state_t;

  // Debug view of every state machine in the block.
  typedef struct packed {
    msg_state_t   msg_state;
    phase_t       phase;
    frame_state_t frame_state;
  } dbg_state_t;

  // Clocks per bit period; truncating divide, never below one clock.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    int cpb;
    cpb = clk_hz / baud;
    return (cpb < 1) ? 1 : cpb;
  endfunction

endpackage

// File: rtl/result_uart_streamer_uart_tx_byte.sv
// Byte sender (uart_tx_byte): shifts one 8N1 frame onto txd, LSB first.
//
// Handshake: tx_valid/tx_data are offered by the producer and held until
// accepted; a byte is accepted on a clock edge where tx_valid && tx_ready.
// tx_ready is high while idle and in the last clock of the stop bit, so a
// byte offered back-to-back starts its start bit right after the stop bit.
module result_uart_streamer_uart_tx_byte
  import result_uart_streamer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_valid,
  input  logic [7:0]   tx_data,
  output logic         tx_ready,
  output logic         txd,
  output frame_state_t frame_state
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  frame_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          bit_end;

  assign bit_end     = (cnt_q == CNT_LAST);
  assign frame_state = state_q;

  // Frame state, bit-period counter, bit index and held byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  // Next-state, line level and ready generation for one frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    data_d   = data_q;
    tx_ready = 1'b0;
    txd      = 1'b1;
    if (state_q != F_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      F_IDLE: begin
        tx_ready = 1'b1;
        cnt_d    = '0;
        if (tx_valid) begin
          state_d = F_START;
          data_d  = tx_data;
        end
      end
      F_START: begin
        txd = 1'b0;
        if (bit_end) begin
          state_d = F_DATA;
          bit_d   = '0;
        end
      end
      F_DATA: begin
        txd = data_q[bit_q];
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = F_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      F_STOP: begin
        txd = 1'b1;
        if (bit_end) begin
          tx_ready = 1'b1;
          if (tx_valid) begin
            state_d = F_START;
            data_d  = tx_data;
          end else begin
            state_d = F_IDLE;
          end
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

endmodule

// File: rtl/result_uart_streamer.sv
// Transmit half of the terminal UART link: latches a packed ASCII message and
// streams it highest byte first as 8N1 frames, optionally followed by CR LF.
module result_uart_streamer
  import result_uart_streamer_pkg::*;
#(
  parameter  int CLK_HZ      = 100_000_000,
  parameter  int BAUD        = 9600,
  parameter  int MAX_BYTES   = MSG_MAX_BYTES,
  parameter  int APPEND_CRLF = 1,
  localparam int LW          = $clog2(MAX_BYTES + 1)
) (
  input  logic                   CLK100MHZ,
  input  logic                   rst,
  input  logic [8*MAX_BYTES-1:0] msg_data,
  input  logic [LW-1:0]          msg_len,
  input  logic                   msg_start,
  output logic                   busy,
  output logic                   done,
  output logic                   dropped,
  output logic                   UART_TXD,
  output dbg_state_t             dbg_state
);

  localparam int            CPB     = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_BYTES);
  localparam bit            CRLF_EN = (APPEND_CRLF != 0);

  msg_state_t    state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    buf_q [MAX_BYTES];
  logic          dropped_q;
  logic          load_buf;

  logic [LW-1:0] len_c;
  phase_t        start_phase;
  logic [LW-1:0] start_idx;
  phase_t        adv_phase;
  logic [LW-1:0] adv_idx;

  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  frame_state_t  frame_state;

  assign busy      = (state_q != MS_IDLE);
  assign done      = (state_q == MS_FIN);
  assign dropped   = dropped_q;
  assign dbg_state = '{msg_state: state_q, phase: phase_q, frame_state: frame_state};

  // Clamp the requested length and pick the first byte source of a message.
  always_comb begin
    len_c       = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
    start_idx   = '0;
    start_phase = CRLF_EN ? PH_CR : PH_END;
    if (len_c != '0) begin
      start_phase = PH_DATA;
      start_idx   = len_c - 1'b1;
    end
  end

  // Byte source following the one currently offered: payload counts down to
  // index 0 without wrapping, then CR, LF, end.
  always_comb begin
    adv_phase = phase_q;
    adv_idx   = idx_q;
    case (phase_q)
      PH_DATA: begin
        if (idx_q != '0) begin
          adv_idx = idx_q - 1'b1;
        end else begin
          adv_phase = CRLF_EN ? PH_CR : PH_END;
        end
      end
      PH_CR:   adv_phase = PH_LF;
      PH_LF:   adv_phase = PH_END;
      default: adv_phase = PH_END;
    endcase
  end

  // Byte offered to the frame sender for the current source.
  always_comb begin
    tx_data = 8'h00;
    case (phase_q)
      PH_DATA: begin
        for (int k = 0; k < MAX_BYTES; k++) begin
          if (idx_q == LW'(k)) begin
            tx_data = buf_q[k];
          end
        end
      end
      PH_CR:   tx_data = ASCII_CR;
      PH_LF:   tx_data = ASCII_LF;
      default: tx_data = 8'h00;
    endcase
  end

  // Message state machine: LOAD offers the first byte, SEND streams the rest
  // and waits for the final stop bit, FIN pulses done for one cycle.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    load_buf = 1'b0;
    tx_valid = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (msg_start) begin
          state_d  = MS_LOAD;
          load_buf = 1'b1;
          phase_d  = start_phase;
          idx_d    = start_idx;
        end
      end
      MS_LOAD: begin
        if (phase_q == PH_END) begin
          state_d = MS_FIN;
        end else begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            phase_d = adv_phase;
            idx_d   = adv_idx;
            state_d = MS_SEND;
          end
        end
      end
      MS_SEND: begin
        if (phase_q == PH_END) begin
          // tx_ready here marks the last clock of the final stop bit.
          if (tx_ready) begin
            state_d = MS_FIN;
          end
        end else begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            phase_d = adv_phase;
            idx_d   = adv_idx;
          end
        end
      end
      MS_FIN:  state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  // Message state, byte source and index registers.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q <= MS_IDLE;
      phase_q <= PH_END;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  // Message buffer is captured on accept; its contents need no reset.
  always_ff @(posedge CLK100MHZ) begin
    if (load_buf) begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        buf_q[k] <= msg_data[8*k +: 8];
      end
    end
  end

  // A request that arrives while busy (including the done cycle) is refused.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= msg_start && busy;
    end
  end

  result_uart_streamer_uart_tx_byte #(
    .CLKS_PER_BIT (CPB)
  ) u_tx_byte (
    .clk         (CLK100MHZ),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .txd         (UART_TXD),
    .frame_state (frame_state)
  );

endmodule
